// File: rtl/montgomery_exp_ctrl.sv
// rtl/montgomery_exp_ctrl.sv - left-to-right square-and-multiply sequencer driving one Montgomery multiplier
module montgomery_exp_ctrl #(
   parameter int WIDTH     = 1024,
   parameter int EXP_WIDTH = 1024,
   parameter int LEN_W     = 11
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 start,
   input  logic [WIDTH-1:0]     in_x,
   input  logic [EXP_WIDTH-1:0] in_e,
   input  logic [LEN_W-1:0]     in_e_len,
   input  logic [WIDTH-1:0]     in_m,
   input  logic [WIDTH-1:0]     in_r_mod_m,
   output logic                 mont_start,
   output logic [WIDTH-1:0]     mont_a,
   output logic [WIDTH-1:0]     mont_b,
   output logic [WIDTH-1:0]     mont_m,
   input  logic [WIDTH-1:0]     mont_result,
   input  logic                 mont_done,
   output logic                 busy,
   output logic                 done,
   output logic [WIDTH-1:0]     result
);

   localparam int IDX_W = $clog2(EXP_WIDTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SQR_ISSUE,
      S_SQR_WAIT,
      S_MUL_ISSUE,
      S_MUL_WAIT,
      S_FINISH
   } state_t;

   state_t                 r_state;
   state_t                 w_next;
   logic [WIDTH-1:0]       r_x;
   logic [EXP_WIDTH-1:0]   r_e;
   logic [WIDTH-1:0]       r_m;
   logic [WIDTH-1:0]       r_acc;
   logic [LEN_W-1:0]       r_idx;
   logic [WIDTH-1:0]       r_result;
   logic                   r_done;
   logic                   r_busy;

   logic                   w_accept;
   logic                   w_last;
   logic                   w_ebit;
   logic                   w_dec;
   logic [LEN_W-1:0]       w_len;

   // A start coinciding with the done pulse is dropped; the next IDLE cycle may accept
   assign w_accept = (r_state == S_IDLE) && start && !r_done;
   assign w_last   = (r_idx == '0);
   assign w_ebit   = r_e[r_idx[IDX_W-1:0]];
   assign w_len    = (in_e_len > LEN_W'(EXP_WIDTH)) ? LEN_W'(EXP_WIDTH) : in_e_len;
   // Every entry into SQR_ISSUE consumes one exponent bit
   assign w_dec    = (w_next == S_SQR_ISSUE);

   // Operands are pure functions of the held registers, so they cannot move during a WAIT
   assign mont_start = (r_state == S_SQR_ISSUE) || (r_state == S_MUL_ISSUE);
   assign mont_a     = r_acc;
   assign mont_b     = ((r_state == S_MUL_ISSUE) || (r_state == S_MUL_WAIT)) ? r_x : r_acc;
   assign mont_m     = r_m;
   assign busy       = r_busy;
   assign done       = r_done;
   assign result     = r_result;

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // Next-state: square first, multiply on a set bit, then step to the next lower bit
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:      if (w_accept) w_next = S_LOAD;
         S_LOAD:      w_next = w_last ? S_FINISH : S_SQR_ISSUE;
         S_SQR_ISSUE: w_next = S_SQR_WAIT;
         S_SQR_WAIT: begin
            if (mont_done) begin
               if (w_ebit)      w_next = S_MUL_ISSUE;
               else if (w_last) w_next = S_FINISH;
               else             w_next = S_SQR_ISSUE;
            end
         end
         S_MUL_ISSUE: w_next = S_MUL_WAIT;
         S_MUL_WAIT: begin
            if (mont_done) w_next = w_last ? S_FINISH : S_SQR_ISSUE;
         end
         S_FINISH:    w_next = S_IDLE;
         default:     w_next = S_IDLE;
      endcase
   end

   // Operand capture, accumulator update, bit index and completion outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_x      <= '0;
         r_e      <= '0;
         r_m      <= '0;
         r_acc    <= '0;
         r_idx    <= '0;
         r_result <= '0;
         r_done   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_x    <= in_x;
            r_e    <= in_e;
            r_m    <= in_m;
            r_acc  <= in_r_mod_m;
            r_idx  <= w_len;
            r_busy <= 1'b1;
         end
         if (mont_done && ((r_state == S_SQR_WAIT) || (r_state == S_MUL_WAIT))) begin
            r_acc <= mont_result;
         end
         if (w_dec) begin
            r_idx <= r_idx - 1'b1;
         end
         if (r_state == S_FINISH) begin
            r_result <= r_acc;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_montgomery_exp_ctrl.sv
// tb/tb_montgomery_exp_ctrl.sv - directed bench with modular-exponent model and stub multiplier
module tb_montgomery_exp_ctrl;

   localparam int W  = 32;
   localparam int EW = 16;
   localparam int LW = 5;

   logic          clk = 1'b0;
   logic          resetn;
   logic          start;
   logic [W-1:0]  in_x, in_m, in_r;
   logic [EW-1:0] in_e;
   logic [LW-1:0] in_e_len;
   logic          mont_start, mont_done, busy, done;
   logic [W-1:0]  mont_a, mont_b, mont_m, mont_result, result;

   logic          spur;
   logic [W-1:0]  spur_val;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int nstarts = 0;

   logic [W-1:0]  exp_a[$];
   logic [W-1:0]  exp_b[$];
   logic [W-1:0]  exp_m;
   logic [W-1:0]  exp_res;

   always #5 clk = ~clk;

   montgomery_exp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW), .LEN_W(LW)) dut (
      .clk(clk), .resetn(resetn), .start(start),
      .in_x(in_x), .in_e(in_e), .in_e_len(in_e_len), .in_m(in_m), .in_r_mod_m(in_r),
      .mont_start(mont_start), .mont_a(mont_a), .mont_b(mont_b), .mont_m(mont_m),
      .mont_result(mont_result), .mont_done(mont_done),
      .busy(busy), .done(done), .result(result)
   );

   // Stub multiplier: plain a*b mod m, done about 5 cycles after the start pulse
   logic [W-1:0] s_a, s_b, s_m, stub_res;
   logic         stub_done, stub_act;
   int           stub_cnt;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s_a <= '0; s_b <= '0; s_m <= '0; stub_res <= '0;
         stub_done <= 1'b0; stub_act <= 1'b0; stub_cnt <= 0;
      end else begin
         stub_done <= 1'b0;
         if (mont_start && !stub_act) begin
            s_a <= mont_a; s_b <= mont_b; s_m <= mont_m;
            stub_act <= 1'b1; stub_cnt <= 4;
         end else if (stub_act) begin
            if (stub_cnt == 0) begin
               stub_act  <= 1'b0;
               stub_done <= 1'b1;
               stub_res  <= W'((64'(s_a) * 64'(s_b)) % 64'(s_m));
            end else begin
               stub_cnt <= stub_cnt - 1;
            end
         end
      end
   end

   assign mont_done   = stub_done | spur;
   assign mont_result = stub_done ? stub_res : spur_val;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Expected multiplier traffic and final value from plain modular exponentiation
   task automatic build_model(input logic [W-1:0] x, input logic [EW-1:0] e, input int len,
                              input logic [W-1:0] m, input logic [W-1:0] r);
      longint unsigned acc;
      int n;
      n = (len > EW) ? EW : len;
      exp_a.delete();
      exp_b.delete();
      exp_m = m;
      acc = r;
      for (int i = n - 1; i >= 0; i--) begin
         exp_a.push_back(W'(acc)); exp_b.push_back(W'(acc));
         acc = (acc * acc) % m;
         if (e[i]) begin
            exp_a.push_back(W'(acc)); exp_b.push_back(x);
            acc = (acc * x) % m;
         end
      end
      exp_res = W'(acc);
   endtask

   // Per-cycle comparison of DUT traffic against the model
   always @(negedge clk) begin
      if (resetn) begin
         if (mont_start) begin
            nstarts++;
            if (exp_a.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_mont_start: got a=%0h b=%0h expected no pulse", mont_a, mont_b);
            end else begin
               chk("op_a", mont_a, exp_a.pop_front());
               chk("op_b", mont_b, exp_b.pop_front());
               chk("op_m", mont_m, exp_m);
            end
         end
         if (stub_act) begin
            chk("stable_a", mont_a, s_a);
            chk("stable_b", mont_b, s_b);
            chk("stable_m", mont_m, s_m);
         end
         if (done) begin
            done_cnt++;
            chk("result", result, exp_res);
            chk("busy_at_done", busy, 0);
         end
      end
   end

   task automatic run_op(input logic [W-1:0] x, input logic [EW-1:0] e, input int len,
                         input logic [W-1:0] m, input logic [W-1:0] r,
                         input bit poke_busy, input bit poke_done,
                         input longint pin_res, input int pin_ops);
      int n;
      build_model(x, e, len, m, r);
      if (pin_res >= 0) chk("model_result", 64'(exp_res), 64'(pin_res));
      if (pin_ops >= 0) chk("model_ops", 64'(exp_a.size()), 64'(pin_ops));
      done_cnt = 0;
      @(posedge clk); #1;
      in_x = x; in_e = e; in_e_len = LW'(len); in_m = m; in_r = r; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (poke_busy) begin
         repeat (10) @(posedge clk);
         #1;
         in_x = 7; in_e = 16'h0003; in_e_len = 2; in_r = 5; start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end
      n = 0;
      while (!done && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) chk("done_timeout", 0, 1);
      if (poke_done) begin
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         @(negedge clk);
         chk("start_at_done_ignored", busy, 0);
      end
      repeat (3) @(negedge clk);
      chk("done_count", done_cnt, 1);
      chk("ops_left", exp_a.size(), 0);
   endtask

   initial begin
      int n;
      resetn = 1'b0; start = 1'b0; spur = 1'b0; spur_val = '0;
      in_x = '0; in_e = '0; in_e_len = '0; in_m = 1; in_r = '0;
      exp_m = '0; exp_res = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_mont_start", mont_start, 0);
      chk("rst_result", result, 0);
      chk("rst_mont_m", mont_m, 0);
      resetn = 1'b1;

      // Zero-length exponent: no multiplications, done three cycles after start is sampled
      build_model(5, 0, 0, 1000, 1);
      chk("model_len0", 64'(exp_res), 1);
      done_cnt = 0; nstarts = 0;
      @(posedge clk); #1;
      in_x = 5; in_e = 0; in_e_len = 0; in_m = 1000; in_r = 1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk); chk("len0_c1_done", done, 0);
      @(negedge clk); chk("len0_c2_done", done, 0);
      @(negedge clk); chk("len0_c3_done", done, 1);
      repeat (2) @(negedge clk);
      chk("len0_done_count", done_cnt, 1);
      chk("len0_no_pulses", nstarts, 0);

      // 3^11 mod 1000 with extra start while busy and start on the done cycle
      nstarts = 0;
      run_op(3, 16'h000B, 4, 1000, 1, 1'b1, 1'b1, 147, 7);
      chk("pulses_147", nstarts, 7);

      // Spurious mont_done while idle must leave everything untouched
      @(posedge clk); #1;
      spur = 1'b1; spur_val = 32'h0000_DEAD;
      @(posedge clk); #1;
      spur = 1'b0;
      @(negedge clk);
      chk("spur_busy", busy, 0);
      chk("spur_result", result, 147);

      // 2^255 mod 65537
      nstarts = 0;
      run_op(2, 16'h00FF, 8, 65537, 1, 1'b0, 1'b0, 32769, 16);
      chk("pulses_255", nstarts, 16);

      // Over-long length clamps to EXP_WIDTH
      run_op(3, 16'h8001, 31, 1000, 1, 1'b0, 1'b0, -1, 18);

      // Reset while waiting on the first squaring
      build_model(3, 16'h000B, 4, 1000, 1);
      nstarts = 0;
      @(posedge clk); #1;
      in_x = 3; in_e = 16'h000B; in_e_len = 4; in_m = 1000; in_r = 1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (nstarts < 1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("reset_test_timeout", 0, 1);
      @(negedge clk);
      resetn = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_mont_start", mont_start, 0);
      chk("midrst_result", result, 0);
      chk("midrst_mont_a", mont_a, 0);
      chk("midrst_mont_b", mont_b, 0);
      chk("midrst_mont_m", mont_m, 0);
      exp_a.delete(); exp_b.delete();
      @(negedge clk);
      resetn = 1'b1;
      run_op(3, 16'h000B, 4, 1000, 1, 1'b0, 1'b0, 147, 7);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
